// File: rtl/mac_pkg.sv
// Shared types and helpers for the accumulating dot-product MAC.
// Tag and saturation arithmetic are carried at 64 bits and narrowed by the user.
package mac_pkg;

   localparam int MAX_ACC_WIDTH = 64;

   typedef logic signed [MAX_ACC_WIDTH-1:0] wide_t;

   typedef struct packed {
      logic  valid;
      logic  first;
      logic  last;
      logic  load;
      wide_t seed;
   } beat_tag_t;

   typedef struct packed {
      wide_t sum;
      logic  ovf;
   } sat_res_t;

   function automatic int tree_width(input int data_width, input int num_lanes);
      return 2 * data_width + $clog2(num_lanes);
   endfunction

   // a and b must already lie in the acc_width signed range; one extra bit of
   // headroom is enough to see any overflow of their sum.
   function automatic sat_res_t sat_add(input wide_t a, input wide_t b,
                                        input int acc_width, input bit saturate);
      logic signed [MAX_ACC_WIDTH:0] full;
      logic signed [MAX_ACC_WIDTH:0] max_v;
      logic signed [MAX_ACC_WIDTH:0] min_v;
      logic signed [MAX_ACC_WIDTH:0] wrapped;
      sat_res_t r;
      full    = {a[MAX_ACC_WIDTH-1], a} + {b[MAX_ACC_WIDTH-1], b};
      min_v   = {(MAX_ACC_WIDTH+1){1'b1}} << (acc_width - 1);
      max_v   = ~min_v;
      wrapped = (full <<< (MAX_ACC_WIDTH + 1 - acc_width)) >>> (MAX_ACC_WIDTH + 1 - acc_width);
      r.ovf   = (full > max_v) || (full < min_v);
      if (r.ovf && saturate)
         r.sum = (full > max_v) ? max_v[MAX_ACC_WIDTH-1:0] : min_v[MAX_ACC_WIDTH-1:0];
      else
         r.sum = wrapped[MAX_ACC_WIDTH-1:0];
      return r;
   endfunction

endpackage

// File: rtl/mac_unit_parallel_acc_if.sv
// Beat input / group result bundle between the operand buffers, the MAC and psum writeback.
interface mac_unit_parallel_acc_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_LANES  = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int K_WIDTH    = 8
);
   logic                                 in_valid;
   logic [NUM_LANES-1:0][DATA_WIDTH-1:0] act_in;
   logic [NUM_LANES-1:0][DATA_WIDTH-1:0] w_in;
   logic [K_WIDTH-1:0]                   k_len;
   logic                                 load_accum;
   logic signed [ACC_WIDTH-1:0]          accum_prev;
   logic signed [ACC_WIDTH-1:0]          result;
   logic                                 result_valid;
   logic                                 result_ovf;
   logic                                 busy;

   modport master (
      output in_valid, act_in, w_in, k_len, load_accum, accum_prev,
      input  result, result_valid, result_ovf, busy
   );

   modport slave (
      input  in_valid, act_in, w_in, k_len, load_accum, accum_prev,
      output result, result_valid, result_ovf, busy
   );
endinterface

// File: rtl/mac_adder_tree.sv
// Binary signed adder tree over NUM_LANES products, one register at the root (S2).
// Every level is carried at the full output width so no level can overflow.
module mac_adder_tree
   import mac_pkg::*;
#(
   parameter int NUM_LANES  = 16,
   parameter int DATA_WIDTH = 8
)(
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NUM_LANES-1:0][2*DATA_WIDTH-1:0]   prod,
   output logic signed [tree_width(DATA_WIDTH, NUM_LANES)-1:0] sum
);
   localparam int SUM_W  = tree_width(DATA_WIDTH, NUM_LANES);
   localparam int LEVELS = $clog2(NUM_LANES);

   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int CNT = NUM_LANES >> l;
      logic signed [SUM_W-1:0] node [CNT];
      for (genvar i = 0; i < CNT; i++) begin : g_node
         if (l == 0) begin : g_leaf
            assign node[i] = SUM_W'($signed(prod[i]));
         end else begin : g_add
            assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         sum <= '0;
      else
         sum <= g_lvl[LEVELS].node[0];
   end
endmodule

// File: rtl/mac_unit_parallel_acc.sv
// N-lane signed dot-product MAC: S0 input reg, S1 products, S2 adder tree, S3 group accumulator.
// A beat accepted at edge t lands in S3 at edge t+3; no backpressure, bubbles flow as invalid tags.
module mac_unit_parallel_acc
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_LANES  = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int K_WIDTH    = 8,
   parameter bit SATURATE   = 1'b1
)(
   input  logic clk,
   input  logic reset,
   mac_unit_parallel_acc_if.slave io
);
   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int SUM_W  = tree_width(DATA_WIDTH, NUM_LANES);

   logic [K_WIDTH-1:0]                   cnt;
   logic [K_WIDTH-1:0]                   k_lat;
   logic [K_WIDTH-1:0]                   k_eff;
   logic                                 beat_first;
   logic                                 beat_last;
   logic [NUM_LANES-1:0][DATA_WIDTH-1:0] act_s0;
   logic [NUM_LANES-1:0][DATA_WIDTH-1:0] w_s0;
   logic [NUM_LANES-1:0][PROD_W-1:0]     prod_s1;
   logic signed [SUM_W-1:0]              sum_s2;
   beat_tag_t                            tag_s0;
   beat_tag_t                            tag_s1;
   beat_tag_t                            tag_s2;
   logic signed [ACC_WIDTH-1:0]          acc;
   logic                                 ovf;
   wide_t                                base;
   sat_res_t                             add_res;
   logic signed [ACC_WIDTH-1:0]          acc_next;
   logic                                 ovf_next;
   logic signed [ACC_WIDTH-1:0]          result_q;
   logic                                 result_valid_q;
   logic                                 result_ovf_q;

   // Group length is only looked at on the first beat; later beats use the latched copy.
   assign beat_first = (cnt == '0);

   always_comb begin
      k_eff = k_lat;
      if (beat_first)
         k_eff = (io.k_len == '0) ? K_WIDTH'(1) : io.k_len;
   end

   assign beat_last = (cnt == k_eff - K_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         k_lat  <= '0;
         tag_s0 <= '0;
      end else begin
         tag_s0 <= '{valid: io.in_valid, first: beat_first, last: beat_last,
                     load: io.load_accum, seed: wide_t'(io.accum_prev)};
         if (io.in_valid) begin
            if (beat_first)
               k_lat <= k_eff;
            cnt <= beat_last ? '0 : cnt + K_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      act_s0 <= io.act_in;
      w_s0   <= io.w_in;
      for (int i = 0; i < NUM_LANES; i++)
         prod_s1[i] <= PROD_W'($signed(act_s0[i])) * PROD_W'($signed(w_s0[i]));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_s1 <= '0;
         tag_s2 <= '0;
      end else begin
         tag_s1 <= tag_s0;
         tag_s2 <= tag_s1;
      end
   end

   mac_adder_tree #(
      .NUM_LANES  (NUM_LANES),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tree (
      .clk   (clk),
      .reset (reset),
      .prod  (prod_s1),
      .sum   (sum_s2)
   );

   always_comb begin
      base = wide_t'(acc);
      if (tag_s2.first)
         base = tag_s2.load ? tag_s2.seed : '0;
      add_res  = sat_add(base, wide_t'(sum_s2), ACC_WIDTH, SATURATE);
      acc_next = add_res.sum[ACC_WIDTH-1:0];
      ovf_next = (tag_s2.first ? 1'b0 : ovf) | add_res.ovf;
   end

   if (ACC_WIDTH < MAX_ACC_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^add_res.sum[MAX_ACC_WIDTH-1:ACC_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc            <= '0;
         ovf            <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         result_ovf_q   <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         if (tag_s2.valid) begin
            acc <= acc_next;
            if (tag_s2.last) begin
               result_q       <= acc_next;
               result_ovf_q   <= ovf_next;
               result_valid_q <= 1'b1;
               ovf            <= 1'b0;
            end else begin
               ovf <= ovf_next;
            end
         end
      end
   end

   assign io.result       = result_q;
   assign io.result_valid = result_valid_q;
   assign io.result_ovf   = result_ovf_q;
   // The pulse cycle counts as S3 occupancy, so busy falls the cycle after it.
   assign io.busy = (cnt != '0) | tag_s0.valid | tag_s1.valid | tag_s2.valid | result_valid_q;
endmodule

// File: tb/tb_mac_unit_parallel_acc.sv
// Directed bench for mac_unit_parallel_acc: vector table plus hand-timed multi-cycle sequences.
module tb_mac_unit_parallel_acc;
   localparam int DW = 8;
   localparam int NL = 16;
   localparam int KW = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mac_unit_parallel_acc_if #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(32), .K_WIDTH(KW)) m ();
   mac_unit_parallel_acc_if #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(20), .K_WIDTH(KW)) s20 ();
   mac_unit_parallel_acc_if #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(20), .K_WIDTH(KW)) w20 ();

   mac_unit_parallel_acc #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(32), .K_WIDTH(KW), .SATURATE(1'b1))
      u_dut (.clk(clk), .reset(reset), .io(m.slave));
   mac_unit_parallel_acc #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(20), .K_WIDTH(KW), .SATURATE(1'b1))
      u_sat (.clk(clk), .reset(reset), .io(s20.slave));
   mac_unit_parallel_acc #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ACC_WIDTH(20), .K_WIDTH(KW), .SATURATE(1'b0))
      u_wrap (.clk(clk), .reset(reset), .io(w20.slave));

   typedef struct {
      int     k;
      int     act;
      int     w;
      int     nl;
      bit     ld;
      longint prev;
      longint exp_res;
      bit     exp_ovf;
   } vec_t;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Lanes >= nl carry a zero activation so partial-lane sums can be built.
   task automatic drive(input bit v, input int a, input int w, input int nl,
                        input int k, input bit ld, input longint prev);
      for (int i = 0; i < NL; i++) begin
         m.act_in[i] = (i < nl) ? DW'(a) : '0;
         m.w_in[i]   = DW'(w);
      end
      m.k_len      = KW'(k);
      m.load_accum = ld;
      m.accum_prev = 32'(prev);
      m.in_valid   = v;
   endtask

   task automatic drive20(input bit v);
      for (int i = 0; i < NL; i++) begin
         s20.act_in[i] = 8'h80;
         s20.w_in[i]   = 8'h80;
         w20.act_in[i] = 8'h80;
         w20.w_in[i]   = 8'h80;
      end
      s20.k_len = KW'(3); w20.k_len = KW'(3);
      s20.load_accum = 1'b0; w20.load_accum = 1'b0;
      s20.accum_prev = '0; w20.accum_prev = '0;
      s20.in_valid = v; w20.in_valid = v;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int nb;
      int pulses;
      nb = (v.k == 0) ? 1 : v.k;
      pulses = 0;
      for (int b = 0; b < nb; b++) begin
         drive(1'b1, v.act, v.w, v.nl, v.k, v.ld, v.prev);
         step();
         if (m.result_valid) pulses++;
      end
      drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
      for (int c = 0; c < 8; c++) begin
         step();
         if (m.result_valid) pulses++;
      end
      chk($sformatf("vec%0d_pulses", idx), pulses, 1);
      chk($sformatf("vec%0d_result", idx), longint'($signed(m.result)), v.exp_res);
      chk($sformatf("vec%0d_ovf", idx), longint'(m.result_ovf), longint'(v.exp_ovf));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   pat[7];
      int   pulses;
      int   p_sat;
      int   p_wrap;

      vecs[0] = '{1, 1, 1, 16, 1'b0, 0, 16, 1'b0};
      vecs[1] = '{4, -2, 3, 16, 1'b0, 0, -384, 1'b0};
      vecs[2] = '{2, 1, 1, 16, 1'b1, 1000, 1032, 1'b0};
      vecs[3] = '{1, 1, 1, 5, 1'b0, 0, 5, 1'b0};
      vecs[4] = '{0, 2, 3, 16, 1'b0, 0, 96, 1'b0};
      vecs[5] = '{3, 127, -128, 16, 1'b0, 0, -780288, 1'b0};
      vecs[6] = '{1, -1, 1, 16, 1'b1, -100, -116, 1'b0};
      vecs[7] = '{2, -128, -128, 16, 1'b1, 2147000000, 2147483647, 1'b1};
      vecs[8] = '{1, -1, 1, 16, 1'b1, -64'sd2147483648, -64'sd2147483648, 1'b1};
      vecs[9] = '{1, 1, 1, 1, 1'b0, 0, 1, 1'b0};

      reset = 1'b1;
      drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
      drive20(1'b0);
      step();
      step();
      chk("rst_result", longint'($signed(m.result)), 0);
      chk("rst_valid", longint'(m.result_valid), 0);
      chk("rst_ovf", longint'(m.result_ovf), 0);
      chk("rst_busy", longint'(m.busy), 0);
      reset = 1'b0;
      step();

      // Single k_len=1 beat: pulse exactly three edges after capture.
      drive(1'b1, 1, 1, 16, 1, 1'b0, 0);
      step();
      chk("lat_t0_valid", longint'(m.result_valid), 0);
      chk("lat_t0_busy", longint'(m.busy), 1);
      drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
      step();
      chk("lat_t1_valid", longint'(m.result_valid), 0);
      step();
      chk("lat_t2_valid", longint'(m.result_valid), 0);
      step();
      chk("lat_t3_valid", longint'(m.result_valid), 1);
      chk("lat_t3_result", longint'($signed(m.result)), 16);
      chk("lat_t3_ovf", longint'(m.result_ovf), 0);
      step();
      chk("lat_t4_valid", longint'(m.result_valid), 0);
      chk("lat_hold_result", longint'($signed(m.result)), 16);

      // Dense k_len=4 group: busy high on the pulse, low right after.
      pulses = 0;
      for (int b = 0; b < 4; b++) begin
         drive(1'b1, -2, 3, 16, 4, 1'b0, 0);
         step();
         if (m.result_valid) pulses++;
      end
      drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
      step();
      if (m.result_valid) pulses++;
      step();
      if (m.result_valid) pulses++;
      chk("dense_early_pulses", pulses, 0);
      step();
      chk("dense_valid", longint'(m.result_valid), 1);
      chk("dense_result", longint'($signed(m.result)), -384);
      chk("dense_busy_pulse", longint'(m.busy), 1);
      step();
      chk("dense_busy_after", longint'(m.busy), 0);
      chk("dense_valid_after", longint'(m.result_valid), 0);

      // Back-to-back groups; beat 2 carries k_len/load changes that must be ignored.
      drive(1'b1, 1, 1, 16, 2, 1'b1, 1000);
      step();
      drive(1'b1, 1, 1, 16, 7, 1'b0, 0);
      step();
      drive(1'b1, 1, 1, 5, 1, 1'b0, 999);
      step();
      drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
      step();
      chk("b2b_t3_valid", longint'(m.result_valid), 0);
      step();
      chk("b2b_g1_valid", longint'(m.result_valid), 1);
      chk("b2b_g1_result", longint'($signed(m.result)), 1032);
      step();
      chk("b2b_g2_valid", longint'(m.result_valid), 1);
      chk("b2b_g2_result", longint'($signed(m.result)), 5);
      step();
      chk("b2b_end_valid", longint'(m.result_valid), 0);

      // Bubbled k_len=4 group must match the dense result.
      pat = '{1, 0, 0, 1, 1, 0, 1};
      pulses = 0;
      for (int p = 0; p < 7; p++) begin
         if (pat[p] != 0) drive(1'b1, -2, 3, 16, 4, 1'b0, 0);
         else             drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
         step();
         if (m.result_valid) pulses++;
      end
      drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
      step();
      if (m.result_valid) pulses++;
      step();
      if (m.result_valid) pulses++;
      chk("bubble_early_pulses", pulses, 0);
      step();
      chk("bubble_valid", longint'(m.result_valid), 1);
      chk("bubble_result", longint'($signed(m.result)), -384);
      step();

      for (int i = 0; i < 10; i++)
         run_vec(i, vecs[i]);

      // 20-bit accumulators, 262144 per beat, three beats: clamp vs wrap.
      p_sat = 0;
      p_wrap = 0;
      for (int b = 0; b < 3; b++) begin
         drive20(1'b1);
         step();
      end
      drive20(1'b0);
      for (int c = 0; c < 8; c++) begin
         step();
         if (s20.result_valid) p_sat++;
         if (w20.result_valid) p_wrap++;
      end
      chk("sat_pulses", p_sat, 1);
      chk("sat_result", longint'($signed(s20.result)), 524287);
      chk("sat_ovf", longint'(s20.result_ovf), 1);
      chk("wrap_pulses", p_wrap, 1);
      chk("wrap_result", longint'($signed(w20.result)), -262144);
      chk("wrap_ovf", longint'(w20.result_ovf), 1);

      // Reset after 2 of 4 beats, then a fresh single-beat group.
      for (int b = 0; b < 2; b++) begin
         drive(1'b1, 1, 1, 16, 4, 1'b0, 0);
         step();
      end
      drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
      reset = 1'b1;
      step();
      chk("midrst_busy", longint'(m.busy), 0);
      chk("midrst_valid", longint'(m.result_valid), 0);
      chk("midrst_result", longint'($signed(m.result)), 0);
      reset = 1'b0;
      drive(1'b1, 1, 1, 16, 1, 1'b0, 0);
      step();
      drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (m.result_valid) pulses++;
      end
      chk("postrst_pulses", pulses, 1);
      chk("postrst_result", longint'($signed(m.result)), 16);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
